// File: rtl/wdog_pkg.sv
// Shared definitions for the multi-channel watchdog: kick-interval status
// classes and the channel-index width helper.
package wdog_pkg;

    typedef enum logic [2:0] {
        WDOG_ST_NONE = 3'd0,
        WDOG_ST_Q1   = 3'd1,
        WDOG_ST_Q2   = 3'd2,
        WDOG_ST_Q3   = 3'd3,
        WDOG_ST_OK   = 3'd4,
        WDOG_ST_LATE = 3'd5
    } wdog_st_e;

    // Width of a channel index; a single channel still gets one select bit.
    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wdog_channel.sv
// One watchdog channel: period register, saturating tick counter, sticky
// timeout flag, kick-interval classifier and optional max-interval tracker.
// Optional feature macro: WDOG_MAX_INTERVAL_EN.
module wdog_channel
    import wdog_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 wr,
    input  logic [CNT_WIDTH-1:0] wdata,
    input  logic                 kick,
    input  logic                 clear,
    output logic                 timeout,
    output logic [2:0]           status,
    output logic [CNT_WIDTH-1:0] max_interval
);

    logic [CNT_WIDTH-1:0] period;
    logic [CNT_WIDTH-1:0] cnt;
    wdog_st_e             status_q;
    logic                 enabled;
    logic                 expire;
    logic [CNT_WIDTH:0]   cnt_inc;
    wdog_st_e             klass;
    logic [CNT_WIDTH+1:0] i1, i4, p1, p2, p3;

    assign status = status_q;

    // Expiry detect and interval classification, widened so 4*I and 3*P cannot overflow.
    always_comb begin
        enabled = (period != '0);
        cnt_inc = {1'b0, cnt} + (CNT_WIDTH+1)'(1);
        expire  = enabled && tick && !kick && !clear && !wr && (cnt_inc >= {1'b0, period});
        i1 = {2'b00, cnt};
        i4 = {cnt, 2'b00};
        p1 = {2'b00, period};
        p2 = {1'b0, period, 1'b0};
        p3 = p2 + p1;
        if (i4 < p1)      klass = WDOG_ST_Q1;
        else if (i4 < p2) klass = WDOG_ST_Q2;
        else if (i4 < p3) klass = WDOG_ST_Q3;
        else if (i1 < p1) klass = WDOG_ST_OK;
        else              klass = WDOG_ST_LATE;
    end

    // Period, counter, status and sticky flag; write beats kick, clear beats expiry.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            period   <= '0;
            cnt      <= '0;
            status_q <= WDOG_ST_NONE;
            timeout  <= 1'b0;
        end else begin
            if (clear)       timeout <= 1'b0;
            else if (expire) timeout <= 1'b1;

            if (wr) begin
                period   <= wdata;
                cnt      <= '0;
                status_q <= WDOG_ST_NONE;
            end else if (!enabled) begin
                cnt <= '0;
            end else begin
                if (kick) status_q <= klass;
                if (clear || kick)
                    cnt <= '0;
                else if (tick && (cnt != '1))
                    cnt <= cnt + CNT_WIDTH'(1);
            end
        end
    end

`ifdef WDOG_MAX_INTERVAL_EN
    logic [CNT_WIDTH-1:0] max_q;

    // Largest interval captured by a kick since reset, write or clear.
    always_ff @(posedge sysclk) begin
        if (reset || wr || clear)
            max_q <= '0;
        else if (enabled && kick && (cnt > max_q))
            max_q <= cnt;
    end

    assign max_interval = max_q;
`else
    assign max_interval = '0;
`endif

endmodule

// File: rtl/wdog_multi.sv
// Multi-channel watchdog top: shared tick prescaler, period-write decode and
// one wdog_channel per QLA. Optional feature macro: WDOG_MAX_INTERVAL_EN.
module wdog_multi
    import wdog_pkg::*;
#(
    parameter  int unsigned NUM_CH    = 2,
    parameter  int unsigned CNT_WIDTH = 16,
    parameter  int unsigned PRESCALE  = 256,
    localparam int unsigned CH_W      = ch_idx_w(NUM_CH)
) (
    input  logic                          sysclk,
    input  logic                          reset,
    input  logic                          per_wen,
    input  logic [CH_W-1:0]               per_ch,
    input  logic [CNT_WIDTH-1:0]          per_wdata,
    input  logic [NUM_CH-1:0]             kick,
    input  logic [NUM_CH-1:0]             wdog_clear,
    output logic [NUM_CH-1:0]             wdog_timeout,
    output logic [3*NUM_CH-1:0]           wdog_period_status,
    output logic                          any_timeout,
    output logic [CNT_WIDTH*NUM_CH-1:0]   max_interval
);

    localparam int unsigned PW = $clog2(PRESCALE);

    logic [PW-1:0] presc;
    logic          tick;
    logic          per_ch_ok;

    assign per_ch_ok = ({1'b0, per_ch} < (CH_W+1)'(NUM_CH));

    // Prescaler; tick is registered so it is high on the cycle the count reads 0 after a wrap.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            presc <= '0;
            tick  <= 1'b0;
        end else if (presc == PW'(PRESCALE-1)) begin
            presc <= '0;
            tick  <= 1'b1;
        end else begin
            presc <= presc + PW'(1);
            tick  <= 1'b0;
        end
    end

    // Summary flag trails the per-channel flags by one cycle.
    always_ff @(posedge sysclk) begin
        if (reset) any_timeout <= 1'b0;
        else       any_timeout <= |wdog_timeout;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        wdog_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
            .sysclk       (sysclk),
            .reset        (reset),
            .tick         (tick),
            .wr           (per_wen && per_ch_ok && (per_ch == CH_W'(i))),
            .wdata        (per_wdata),
            .kick         (kick[i]),
            .clear        (wdog_clear[i]),
            .timeout      (wdog_timeout[i]),
            .status       (wdog_period_status[3*i +: 3]),
            .max_interval (max_interval[CNT_WIDTH*i +: CNT_WIDTH])
        );
    end

endmodule
